icache_ctrl_nway: RTL and testbench

Parametrised N-way set-associative instruction-cache controller. It replaces the fixed two-way controller and adds multi-beat line refill, victim selection and optional performance counters. It sits between the fetch stage and the instruction-memory interface. It consumes per-way tag-compare results from the icache datapath and drives per-way write enables and the line-valid update back into it.

---
 rtl/cache_defs.sv | 14 +
 rtl/icache_victim_sel.sv | 24 ++
 rtl/icache_ctrl_nway.sv | 142 ++++++++++++++
 tb/tb_icache_ctrl_nway.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_defs.sv
// Shared definitions for the N-way instruction-cache controller.
package cache_defs;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    DONE = 2'd2
  } type_icache_ctrl_states_e;

  localparam int ICACHE_NWAYS      = 4;
  localparam int ICACHE_NSETS      = 64;
  localparam int ICACHE_LINE_BEATS = 4;

endpackage

// File: rtl/icache_victim_sel.sv
// Victim way selection: lowest-index invalid way, else the set's round-robin pointer.
module icache_victim_sel #(
  parameter int NWAYS = 4,
  parameter int VW    = $clog2(NWAYS)
) (
  input  logic [NWAYS-1:0] way_valid_i,
  input  logic [VW-1:0]    rr_ptr_i,
  output logic [VW-1:0]    victim_o,
  output logic             from_rr_o
);

  // Scan high to low so the lowest invalid way is the last one to win.
  always_comb begin
    victim_o  = rr_ptr_i;
    from_rr_o = 1'b1;
    for (int w = NWAYS - 1; w >= 0; w--) begin
      if (!way_valid_i[w]) begin
        victim_o  = VW'(w);
        from_rr_o = 1'b0;
      end
    end
  end

endmodule

// File: rtl/icache_ctrl_nway.sv
// N-way set-associative instruction-cache controller with multi-beat refill.
// Optional hit/miss counters are enabled by defining ICACHE_PERF_EN.
module icache_ctrl_nway
  import cache_defs::*;
#(
  parameter int NWAYS      = ICACHE_NWAYS,
  parameter int NSETS      = ICACHE_NSETS,
  parameter int LINE_BEATS = ICACHE_LINE_BEATS,
  parameter int SW         = (NSETS > 1) ? $clog2(NSETS) : 1,
  parameter int BW         = (LINE_BEATS > 1) ? $clog2(LINE_BEATS) : 1,
  parameter int VW         = $clog2(NWAYS)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             if2icache_req_i,
  input  logic             if2icache_req_kill_i,
  input  logic             imem_sel_i,
  input  logic [SW-1:0]    set_idx_i,
  input  logic [NWAYS-1:0] way_hit_i,
  input  logic [NWAYS-1:0] way_valid_i,
  output logic             icache2if_ack_o,
  output logic             icache2mem_req_o,
  input  logic             mem2icache_ack_i,
  output logic [BW-1:0]    beat_idx_o,
  output logic [NWAYS-1:0] way_we_o,
  output logic             line_valid_o,
  output logic [VW-1:0]    victim_way_o
`ifdef ICACHE_PERF_EN
  ,
  output logic [31:0]      hit_cnt_o,
  output logic [31:0]      miss_cnt_o
`endif
);

  type_icache_ctrl_states_e state_q;

  logic                     ack_q;
  logic [BW-1:0]            beat_q;
  logic [VW-1:0]            victim_q;
  logic                     from_rr_q;
  logic [SW-1:0]            set_q;
  logic [NSETS-1:0][VW-1:0] rr_q;

  logic          active, hit, miss, abort, in_fill, beat_fire, last_beat;
  logic [VW-1:0] vs_victim;
  logic          vs_from_rr;

  assign active    = if2icache_req_i & imem_sel_i & ~if2icache_req_kill_i;
  assign hit       = active & (|way_hit_i);
  assign miss      = active & ~(|way_hit_i);
  // A new PC or a non-cacheable address abandons the refill on the spot.
  assign abort     = if2icache_req_kill_i | ~imem_sel_i;
  assign in_fill   = (state_q == FILL);
  assign beat_fire = in_fill & ~abort & mem2icache_ack_i;
  assign last_beat = (beat_q == BW'(LINE_BEATS - 1));

  icache_victim_sel #(.NWAYS(NWAYS), .VW(VW)) u_victim_sel (
    .way_valid_i (way_valid_i),
    .rr_ptr_i    (rr_q[set_idx_i]),
    .victim_o    (vs_victim),
    .from_rr_o   (vs_from_rr)
  );

  // Memory request and line commit follow the ack combinationally so a kill masks them in-cycle.
  assign icache2mem_req_o = in_fill & ~abort;
  assign line_valid_o     = beat_fire & last_beat;
  assign icache2if_ack_o  = ack_q;
  assign beat_idx_o       = beat_q;
  assign victim_way_o     = victim_q;

  // One-hot data write enable for the way being refilled.
  always_comb begin
    way_we_o = '0;
    if (beat_fire) way_we_o[victim_q] = 1'b1;
  end

  // Controller FSM: hit ack, miss capture, beat counting and round-robin update.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      ack_q     <= 1'b0;
      beat_q    <= '0;
      victim_q  <= '0;
      from_rr_q <= 1'b0;
      set_q     <= '0;
      rr_q      <= '0;
    end else begin
      ack_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (hit) begin
            ack_q <= 1'b1;
          end else if (miss) begin
            set_q     <= set_idx_i;
            victim_q  <= vs_victim;
            from_rr_q <= vs_from_rr;
            beat_q    <= '0;
            state_q   <= FILL;
          end
        end
        FILL: begin
          if (abort) begin
            state_q <= IDLE;
          end else if (mem2icache_ack_i) begin
            beat_q <= beat_q + BW'(1);
            if (last_beat) begin
              state_q <= DONE;
              // Only a round-robin pick advances the pointer; filling a hole leaves it alone.
              if (from_rr_q) rr_q[set_q] <= victim_q + VW'(1);
            end
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef ICACHE_PERF_EN
  logic [31:0] hit_cnt_q, miss_cnt_q;

  // Saturating hit/miss counters; a miss is counted on the IDLE-to-FILL transition.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else if (state_q == IDLE) begin
      if (hit && (hit_cnt_q != 32'hFFFF_FFFF))   hit_cnt_q  <= hit_cnt_q + 32'd1;
      if (miss && (miss_cnt_q != 32'hFFFF_FFFF)) miss_cnt_q <= miss_cnt_q + 32'd1;
    end
  end

  assign hit_cnt_o  = hit_cnt_q;
  assign miss_cnt_o = miss_cnt_q;
`endif

`ifndef SYNTHESIS
  a_way_hit_onehot: assert property (@(posedge clk_i) disable iff (rst_i)
    active |-> $onehot0(way_hit_i));
`endif

endmodule

// File: tb/tb_icache_ctrl_nway.sv
// Directed bench for icache_ctrl_nway (NWAYS=4, NSETS=64, LINE_BEATS=4).
module tb_icache_ctrl_nway;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       req, kill, sel, mem_ack;
  logic [5:0] set_idx;
  logic [3:0] way_hit, way_valid;
  logic       ack, mem_req, line_valid;
  logic [1:0] beat_idx, victim_way;
  logic [3:0] way_we;
`ifdef ICACHE_PERF_EN
  logic [31:0] hit_cnt, miss_cnt;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    int   way;
    int   beat;
    logic lv;
  } exp_t;
  exp_t exp_q[$];

  always #5 clk_i = ~clk_i;

  icache_ctrl_nway dut (
    .clk_i                (clk_i),
    .rst_i                (rst_i),
    .if2icache_req_i      (req),
    .if2icache_req_kill_i (kill),
    .imem_sel_i           (sel),
    .set_idx_i            (set_idx),
    .way_hit_i            (way_hit),
    .way_valid_i          (way_valid),
    .icache2if_ack_o      (ack),
    .icache2mem_req_o     (mem_req),
    .mem2icache_ack_i     (mem_ack),
    .beat_idx_o           (beat_idx),
    .way_we_o             (way_we),
    .line_valid_o         (line_valid),
    .victim_way_o         (victim_way)
`ifdef ICACHE_PERF_EN
    ,
    .hit_cnt_o            (hit_cnt),
    .miss_cnt_o           (miss_cnt)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every data-array write is matched against the beat the bench acknowledged.
  always @(negedge clk_i) begin
    if (!rst_i && (way_we != 4'b0 || line_valid)) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", {27'b0, line_valid, way_we}, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("way_we", {28'b0, way_we}, 32'(4'b0001 << e.way));
        check("beat_idx", {30'b0, beat_idx}, 32'(e.beat));
        check("line_valid", {31'b0, line_valid}, {31'b0, e.lv});
      end
    end
  end

  task automatic step();
    @(posedge clk_i); #1;
  endtask

  task automatic do_hit(input int set, input logic [3:0] hitv);
    req = 1'b1; sel = 1'b1; kill = 1'b0; set_idx = 6'(set); way_hit = hitv; way_valid = 4'hF;
    @(negedge clk_i);
    check("hit_no_memreq", {31'b0, mem_req}, 32'd0);
    step();
    req = 1'b0; way_hit = 4'b0;
    @(negedge clk_i);
    check("hit_ack", {31'b0, ack}, 32'd1);
    check("hit_no_memreq_after", {31'b0, mem_req}, 32'd0);
    step();
  endtask

  task automatic start_miss(input int set, input logic [3:0] valid);
    req = 1'b1; sel = 1'b1; kill = 1'b0; set_idx = 6'(set); way_hit = 4'b0; way_valid = valid;
    @(negedge clk_i);
    check("miss_decide_no_memreq", {31'b0, mem_req}, 32'd0);
    step();
    req = 1'b0; way_valid = 4'hF;
  endtask

  task automatic beat(input int vict, input int b, input int dly);
    repeat (dly) begin
      @(negedge clk_i);
      check("fill_req_held", {31'b0, mem_req}, 32'd1);
      check("fill_no_we", {28'b0, way_we}, 32'd0);
      check("fill_no_ack", {31'b0, ack}, 32'd0);
      step();
    end
    mem_ack = 1'b1;
    exp_q.push_back('{vict, b, (b == 3)});
    @(negedge clk_i);
    check("victim_way", {30'b0, victim_way}, 32'(vict));
    check("fill_req_beat", {31'b0, mem_req}, 32'd1);
    step();
    mem_ack = 1'b0;
    check("beat_consumed", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic finish_done();
    @(negedge clk_i);
    check("done_no_memreq", {31'b0, mem_req}, 32'd0);
    check("done_no_we", {28'b0, way_we}, 32'd0);
    check("done_no_lv", {31'b0, line_valid}, 32'd0);
    check("done_no_ack", {31'b0, ack}, 32'd0);
    step();
  endtask

  task automatic fill(input int set, input logic [3:0] valid, input int vict, input int dly);
    start_miss(set, valid);
    for (int b = 0; b < 4; b++) beat(vict, b, dly);
    finish_done();
  endtask

  // Abort after nok good beats by raising kill (or dropping imem_sel) alongside an ack.
  task automatic aborted_fill(input int set, input int vict, input int nok, input bit use_sel);
    start_miss(set, 4'hF);
    for (int b = 0; b < nok; b++) beat(vict, b, 0);
    mem_ack = 1'b1;
    if (use_sel) sel = 1'b0; else kill = 1'b1;
    @(negedge clk_i);
    check("abort_no_memreq", {31'b0, mem_req}, 32'd0);
    check("abort_no_we", {28'b0, way_we}, 32'd0);
    check("abort_no_lv", {31'b0, line_valid}, 32'd0);
    step();
    kill = 1'b0; sel = 1'b1;
    // Still acking: back in IDLE nothing may be written or requested.
    @(negedge clk_i);
    check("abort_idle_memreq", {31'b0, mem_req}, 32'd0);
    check("abort_idle_we", {28'b0, way_we}, 32'd0);
    step();
    mem_ack = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_i = 1'b1; req = 1'b0; kill = 1'b0; sel = 1'b1; mem_ack = 1'b0;
    set_idx = '0; way_hit = '0; way_valid = 4'hF;
    repeat (3) step();
    rst_i = 1'b0;
    @(negedge clk_i);
    check("rst_ack", {31'b0, ack}, 32'd0);
    check("rst_memreq", {31'b0, mem_req}, 32'd0);
    check("rst_we", {28'b0, way_we}, 32'd0);
    check("rst_lv", {31'b0, line_valid}, 32'd0);
    check("rst_beat", {30'b0, beat_idx}, 32'd0);
    check("rst_victim", {30'b0, victim_way}, 32'd0);
    step();

    // Hit with a 1-cycle ack.
    do_hit(3, 4'b0100);

    // Cold miss: ways 0,1 valid -> victim 2, each ack two cycles late; then re-presented hit.
    fill(7, 4'b0011, 2, 2);
    do_hit(7, 4'b0100);

    // Invalid way wins over rr (rr[5] stays 0), then rr walks 0,1,2,3 and wraps to 0.
    fill(5, 4'b0111, 3, 1);
    fill(5, 4'hF, 0, 0);
    fill(5, 4'hF, 1, 0);
    fill(5, 4'hF, 2, 0);
    fill(5, 4'hF, 3, 0);
    fill(5, 4'hF, 0, 1);

    // Kill after beat 1; rr[9] must stay 0.
    aborted_fill(9, 0, 2, 1'b0);
    fill(9, 4'hF, 0, 0);
    // Kill on the last beat suppresses line_valid; rr[11] stays 0.
    aborted_fill(11, 0, 3, 1'b0);
    fill(11, 4'hF, 0, 0);
    // imem_sel dropping mid-fill aborts the same way; rr[9] is 1 after the fill above.
    aborted_fill(9, 1, 1, 1'b1);
    fill(9, 4'hF, 1, 0);

    // Reset while waiting for beat 2; rr[5] is 1 before and 0 after.
    start_miss(5, 4'hF);
    beat(1, 0, 0);
    beat(1, 1, 0);
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    @(negedge clk_i);
    check("midrst_memreq", {31'b0, mem_req}, 32'd0);
    check("midrst_we", {28'b0, way_we}, 32'd0);
    check("midrst_lv", {31'b0, line_valid}, 32'd0);
    check("midrst_beat", {30'b0, beat_idx}, 32'd0);
    check("midrst_victim", {30'b0, victim_way}, 32'd0);
    check("midrst_ack", {31'b0, ack}, 32'd0);
`ifdef ICACHE_PERF_EN
    check("midrst_hit_cnt", hit_cnt, 32'd0);
    check("midrst_miss_cnt", miss_cnt, 32'd0);
`endif
    step();

`ifdef ICACHE_PERF_EN
    do_hit(1, 4'b0001);
    do_hit(2, 4'b0010);
    do_hit(3, 4'b1000);
`endif
    fill(5, 4'hF, 0, 1);
`ifdef ICACHE_PERF_EN
    @(negedge clk_i);
    check("perf_hit_cnt", hit_cnt, 32'd3);
    check("perf_miss_cnt", miss_cnt, 32'd1);
    step();
    force dut.hit_cnt_q = 32'hFFFF_FFFF;
    step();
    release dut.hit_cnt_q;
    do_hit(4, 4'b0001);
    @(negedge clk_i);
    check("perf_hit_saturate", hit_cnt, 32'hFFFF_FFFF);
    step();
`endif

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
